mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (read-only) and the load/store requester (read/write).
- Sits between the PC/fetch stage, the load/store path and the memory macro.
- Supports one outstanding transaction at a time with a fixed memory read latency.
- Load/store has default priority; a starvation counter guarantees fetch progress.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LATENCY, 2, cycles from address issue to mem_rdata_i valid (>=1)
- STARVE_LIMIT, 4, consecutive contended losses by fetch before fetch is favoured; 0 = strict load/store priority

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_gnt_o
- if_addr_i  in  AW  fetch address
- if_gnt_o  out  1  fetch accepted this cycle
- if_rvalid_o  out  1  one-cycle pulse, if_rdata_o valid
- if_rdata_o  out  DW  fetched word
- dm_req_i  in  1  load/store request, held until dm_gnt_o
- dm_we_i  in  1  1 = store
- dm_addr_i  in  AW  load/store address
- dm_wdata_i  in  DW  store data
- dm_gnt_o  out  1  load/store accepted this cycle
- dm_rvalid_o  out  1  one-cycle completion pulse (loads and stores)
- dm_rdata_o  out  DW  load data; 0 for stores
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data
- busy_o  out  1  transaction outstanding

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - Starve counter, latency counter, owner, if_rvalid_o, dm_rvalid_o, if_rdata_o and dm_rdata_o all go to 0.
  - Any in-flight transaction is dropped with no rvalid.
  - Combinational outputs read 0 in IDLE with no request.
- FSM states: IDLE and BUSY.
- IDLE:
  - If any request is pending, select a winner.
  - Combinationally assert the winner's gnt_o and mem_en_o.
  - Drive mem_addr_o from the winner; drive mem_we_o/mem_wdata_o from the winner (0 for fetch).
  - Record the owner, load the latency counter with MEM_LATENCY, and move to BUSY.
  - No request: stay in IDLE; mem_* outputs are 0.
- Arbitration when both requests are high in IDLE:
  - Load/store wins unless STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - A load/store grant while if_req_i is high increments starve_cnt, saturating at STARVE_LIMIT.
  - A fetch grant clears starve_cnt to 0.
  - A lone requester always wins.
- BUSY:
  - gnt outputs are 0 and mem_en_o is 0.
  - The counter decrements each cycle.
  - Issue happens in cycle T. mem_rdata_i is sampled at the end of cycle T+MEM_LATENCY into the owner's rdata register; stores capture 0.
  - The state returns to IDLE at that same edge.
- Response:
  - Owner's rvalid_o is high for exactly cycle T+MEM_LATENCY+1, together with the rdata.
  - The other port's rdata holds its previous value.
- Back-to-back:
  - A new grant may occur in cycle T+MEM_LATENCY+1, concurrently with the rvalid pulse.
  - Peak throughput is one transaction per MEM_LATENCY+1 cycles.
- Stores occupy the same MEM_LATENCY+1 slot and ack via dm_rvalid_o.
- A request deasserted before its grant is simply not served; the requester protocol forbids this, so there is no assertion.
- busy_o = (state == BUSY).
- Widths: addresses and data pass through unmodified. There is no alignment check here; misalignment is the requester's concern.

Test Plan:
- Single fetch, MEM_LATENCY=2:
  - Stimulus: if_req_i=1, if_addr_i=0x0000_0010 at cycle 0; mem_rdata_i=0xDEAD_BEEF at cycle 2.
  - Required response: if_gnt_o=1 in cycle 0, mem_en_o=1, mem_addr_o=0x10; if_rvalid_o=1 only in cycle 3 with if_rdata_o=0xDEAD_BEEF; busy_o=1 in cycles 1-2.
- Contention:
  - Stimulus: if_req_i and dm_req_i (load, 0x100) both high at cycle 0.
  - Required response: dm_gnt_o in cycle 0; if_gnt_o in cycle 3; dm_rvalid_o in cycle 3; if_rvalid_o in cycle 6.
- Starvation, STARVE_LIMIT=2, both requests held continuously:
  - Required grant order: dm, dm, if, dm, dm, if.
  - starve_cnt reaches 2 before each fetch grant.
- Store:
  - Stimulus: dm_we_i=1, dm_addr_i=0x200, dm_wdata_i=0x1234_5678.
  - Required response: mem_we_o=1 and mem_wdata_o=0x1234_5678 in the grant cycle only; dm_rvalid_o pulses 3 cycles later with dm_rdata_o=0.
- Reset mid-operation:
  - Stimulus: drop rst in cycle 1 of a fetch, then release.
  - Required response: no if_rvalid_o; busy_o=0 immediately; a new request is granted on the first cycle after release.
- Back-to-back fetches:
  - Stimulus: if_req_i held high for 3 transactions.
  - Required response: grants in cycles 0, 3, 6; rvalid pulses in cycles 3, 6, 9 coinciding with the next grants.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch (read-only) and load/store share one memory,
// one outstanding transaction, fixed read latency, starvation-bounded load/store priority.
module mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_gnt_o,
  output logic          dm_rvalid_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int unsigned LW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  logic idle;
  logic favour_if;
  logic grant_if;
  logic grant_dm;

  assign idle      = (state_q == S_IDLE);
  // With STARVE_LIMIT == 0 the counter is pinned at 0, so fetch is never favoured.
  assign favour_if = (STARVE_LIMIT != 0) && (starve_q == SW'(STARVE_LIMIT));
  assign grant_dm  = idle && dm_req_i && !(if_req_i && favour_if);
  assign grant_if  = idle && if_req_i && !grant_dm;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    we_d        = we_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_dm || grant_if) begin
          state_d = S_BUSY;
          lat_d   = LW'(MEM_LATENCY);
          owner_d = grant_dm ? OWN_DM : OWN_IF;
          we_d    = grant_dm && dm_we_i;
          if (grant_if) begin
            starve_d = '0;
          end else if (if_req_i && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      S_BUSY: begin
        if (lat_q <= LW'(1)) begin
          state_d = S_IDLE;
          lat_d   = '0;
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = we_q ? '0 : mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt_o    = grant_if;
  assign dm_gnt_o    = grant_dm;
  assign mem_en_o    = grant_if || grant_dm;
  assign mem_we_o    = grant_dm && dm_we_i;
  assign mem_addr_o  = grant_dm ? dm_addr_i : (grant_if ? if_addr_i : '0);
  assign mem_wdata_o = grant_dm ? dm_wdata_i : '0;

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign busy_o      = (state_q == S_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LATENCY=2, STARVE_LIMIT=2): cycle table plus
// hand sequences for starvation rotation and reset during a transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0, dm_wdata_i = '0;
  logic        dm_gnt_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(2), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o(dm_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_if_rv;
    logic [31:0] e_if_rdata;
    logic        e_dm_rv;
    logic [31:0] e_dm_rdata;
    logic        e_busy;
  } vec_t;

  vec_t v [26];

  function automatic vec_t mk(
    logic ifr, logic [31:0] ifa, logic dmr, logic we, logic [31:0] dma,
    logic [31:0] wd, logic [31:0] mrd,
    logic gif, logic gdm, logic en, logic mwe, logic [31:0] maddr, logic [31:0] mwd,
    logic ifrv, logic [31:0] ifrd, logic dmrv, logic [31:0] dmrd, logic bsy);
    vec_t r;
    r.if_req = ifr; r.if_addr = ifa; r.dm_req = dmr; r.dm_we = we;
    r.dm_addr = dma; r.dm_wdata = wd; r.mem_rdata = mrd;
    r.e_if_gnt = gif; r.e_dm_gnt = gdm; r.e_mem_en = en; r.e_mem_we = mwe;
    r.e_mem_addr = maddr; r.e_mem_wdata = mwd;
    r.e_if_rv = ifrv; r.e_if_rdata = ifrd; r.e_dm_rv = dmrv; r.e_dm_rdata = dmrd;
    r.e_busy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp_if [6];
    int ngr;
    int last_cyc;
    int cyc;

    //       ifr ifa      dmr we dma     wd           mrd           gif gdm en mwe maddr   mwd           ifrv ifrd          dmrv dmrd          busy
    v[0]  = mk(1, 32'h10, 0, 0, 32'h0,   32'h0,       32'h0,        1, 0, 1, 0, 32'h10,  32'h0,        0, 32'h0,        0, 32'h0,        0);
    v[1]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        1);
    v[2]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'hDEADBEEF, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        1);
    v[3]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        0);
    v[4]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        0);
    v[5]  = mk(1, 32'h20, 1, 0, 32'h100, 32'h0,       32'h0,        0, 1, 1, 0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        0);
    v[6]  = mk(1, 32'h20, 0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        1);
    v[7]  = mk(1, 32'h20, 0, 0, 32'h0,   32'h0,       32'hCAFE0001, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        1);
    v[8]  = mk(1, 32'h20, 0, 0, 32'h0,   32'h0,       32'h0,        1, 0, 1, 0, 32'h20,  32'h0,        0, 32'hDEADBEEF, 1, 32'hCAFE0001, 0);
    v[9]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'hDEADBEEF, 0, 32'hCAFE0001, 1);
    v[10] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0BADF00D, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'hDEADBEEF, 0, 32'hCAFE0001, 1);
    v[11] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        1, 32'h0BADF00D, 0, 32'hCAFE0001, 0);
    v[12] = mk(0, 32'h0,  1, 1, 32'h200, 32'h12345678, 32'h0,       0, 1, 1, 1, 32'h200, 32'h12345678, 0, 32'h0BADF00D, 0, 32'hCAFE0001, 0);
    v[13] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0BADF00D, 0, 32'hCAFE0001, 1);
    v[14] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'hFFFFFFFF, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0BADF00D, 0, 32'hCAFE0001, 1);
    v[15] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0BADF00D, 1, 32'h0,        0);
    v[16] = mk(1, 32'h40, 0, 0, 32'h0,   32'h0,       32'h0,        1, 0, 1, 0, 32'h40,  32'h0,        0, 32'h0BADF00D, 0, 32'h0,        0);
    v[17] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0BADF00D, 0, 32'h0,        1);
    v[18] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h11111111, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0BADF00D, 0, 32'h0,        1);
    v[19] = mk(1, 32'h44, 0, 0, 32'h0,   32'h0,       32'h0,        1, 0, 1, 0, 32'h44,  32'h0,        1, 32'h11111111, 0, 32'h0,        0);
    v[20] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h11111111, 0, 32'h0,        1);
    v[21] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h22222222, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h11111111, 0, 32'h0,        1);
    v[22] = mk(1, 32'h48, 0, 0, 32'h0,   32'h0,       32'h0,        1, 0, 1, 0, 32'h48,  32'h0,        1, 32'h22222222, 0, 32'h0,        0);
    v[23] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h22222222, 0, 32'h0,        1);
    v[24] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h33333333, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h22222222, 0, 32'h0,        1);
    v[25] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,       32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        1, 32'h33333333, 0, 32'h0,        0);

    // Reset state
    #3;
    chk("rst busy", 32'(busy_o), 0);
    chk("rst if_rvalid", 32'(if_rvalid_o), 0);
    chk("rst dm_rvalid", 32'(dm_rvalid_o), 0);
    chk("rst if_rdata", if_rdata_o, 0);
    chk("rst dm_rdata", dm_rdata_o, 0);
    chk("rst mem_en", 32'(mem_en_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    next_cycle();

    // Table: single fetch, contention, store, back-to-back fetches
    for (int i = 0; i < 26; i++) begin
      if_req_i    = v[i].if_req;
      if_addr_i   = v[i].if_addr;
      dm_req_i    = v[i].dm_req;
      dm_we_i     = v[i].dm_we;
      dm_addr_i   = v[i].dm_addr;
      dm_wdata_i  = v[i].dm_wdata;
      mem_rdata_i = v[i].mem_rdata;
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", i), 32'(if_gnt_o), 32'(v[i].e_if_gnt));
      chk($sformatf("v%0d dm_gnt", i), 32'(dm_gnt_o), 32'(v[i].e_dm_gnt));
      chk($sformatf("v%0d mem_en", i), 32'(mem_en_o), 32'(v[i].e_mem_en));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we_o), 32'(v[i].e_mem_we));
      if (v[i].e_mem_en) begin
        chk($sformatf("v%0d mem_addr", i), mem_addr_o, v[i].e_mem_addr);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, v[i].e_mem_wdata);
      end
      chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid_o), 32'(v[i].e_if_rv));
      chk($sformatf("v%0d if_rdata", i), if_rdata_o, v[i].e_if_rdata);
      chk($sformatf("v%0d dm_rvalid", i), 32'(dm_rvalid_o), 32'(v[i].e_dm_rv));
      chk($sformatf("v%0d dm_rdata", i), dm_rdata_o, v[i].e_dm_rdata);
      chk($sformatf("v%0d busy", i), 32'(busy_o), 32'(v[i].e_busy));
      next_cycle();
    end

    // Starvation rotation with both requests held
    exp_if = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ngr = 0;
    last_cyc = 0;
    if_req_i = 1'b1; if_addr_i = 32'h300;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h400; dm_wdata_i = '0;
    mem_rdata_i = '0;
    for (cyc = 0; cyc < 60 && ngr < 6; cyc++) begin
      @(negedge clk);
      if (if_gnt_o || dm_gnt_o) begin
        chk($sformatf("starve grant%0d is_fetch", ngr), 32'(if_gnt_o), 32'(exp_if[ngr]));
        chk($sformatf("starve grant%0d dual", ngr), 32'(if_gnt_o && dm_gnt_o), 0);
        if (exp_if[ngr]) chk($sformatf("starve grant%0d cnt", ngr), 32'(dut.starve_q), 2);
        if (ngr > 0) chk($sformatf("starve grant%0d spacing", ngr), 32'(cyc - last_cyc), 3);
        last_cyc = cyc;
        ngr++;
      end
      next_cycle();
    end
    chk("starve grant count", 32'(ngr), 6);
    if_req_i = 1'b0; dm_req_i = 1'b0;
    for (int k = 0; k < 10 && busy_o; k++) next_cycle();
    chk("starve drain", 32'(busy_o), 0);
    next_cycle();

    // Reset during a fetch
    if_req_i = 1'b1; if_addr_i = 32'h80;
    @(negedge clk);
    chk("rmid grant", 32'(if_gnt_o), 1);
    next_cycle();
    if_req_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rmid busy", 32'(busy_o), 0);
    chk("rmid if_rvalid", 32'(if_rvalid_o), 0);
    repeat (2) begin
      @(negedge clk);
      chk("rmid hold rvalid", 32'(if_rvalid_o), 0);
    end
    next_cycle();
    rst = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h84; mem_rdata_i = '0;
    @(negedge clk);
    chk("rmid regrant", 32'(if_gnt_o), 1);
    chk("rmid regrant addr", mem_addr_o, 32'h84);
    chk("rmid regrant rvalid", 32'(if_rvalid_o), 0);
    next_cycle();
    if_req_i = 1'b0;
    @(negedge clk);
    chk("rmid t1 rvalid", 32'(if_rvalid_o), 0);
    next_cycle();
    mem_rdata_i = 32'h5A5A5A5A;
    @(negedge clk);
    chk("rmid t2 rvalid", 32'(if_rvalid_o), 0);
    next_cycle();
    mem_rdata_i = '0;
    @(negedge clk);
    chk("rmid t3 rvalid", 32'(if_rvalid_o), 1);
    chk("rmid t3 rdata", if_rdata_o, 32'h5A5A5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
